// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single core memory port between instruction fetch
// and load/store. One transaction is in flight at a time. Ties are broken
// round-robin, and every transaction is bounded by a timeout so that a dead
// memory returns an error instead of hanging the core.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      global_rst,
    input  logic                      if_req_valid,
    output logic                      if_req_ready,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_resp_valid,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_err,
    input  logic                      ls_req_valid,
    output logic                      ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]     ls_addr,
    input  logic                      ls_we,
    input  logic [DATA_WIDTH/8-1:0]   ls_wmask,
    input  logic [DATA_WIDTH-1:0]     ls_wdata,
    output logic                      ls_resp_valid,
    output logic [DATA_WIDTH-1:0]     ls_rdata,
    output logic                      ls_err,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_err
);

    // Counter is wide enough to reach TIMEOUT; one extra bit in the compare
    // keeps the incremented value from wrapping before it is tested.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW:0] TIMEOUT_LIMIT = (CW + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t                state;
    owner_t                owner;
    owner_t                last_grant;
    logic [CW-1:0]         count;
    logic [CW:0]           count_next;
    logic                  timeout_hit;
    logic                  grant_ls;
    logic                  idle_open;
    logic                  finish;
    logic [DATA_WIDTH-1:0] fin_rdata;
    logic                  fin_err;

    assign count_next  = {1'b0, count} + (CW + 1)'(1);
    assign timeout_hit = (TIMEOUT != 0) && (count_next == TIMEOUT_LIMIT);

    // Readies are held low while reset is asserted so every output reads 0.
    assign idle_open    = (state == S_IDLE) && !global_rst;
    assign ls_req_ready = idle_open && grant_ls;
    assign if_req_ready = idle_open && if_req_valid && !grant_ls;

    // Pick the requester to serve: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_ls = 1'b0;
        if (ls_req_valid && if_req_valid) begin
            grant_ls = (last_grant == OWN_IF);
        end else begin
            grant_ls = ls_req_valid;
        end
    end

    // Decide whether the transaction ends this cycle; a real response beats a simultaneous timeout.
    always_comb begin
        finish    = 1'b0;
        fin_rdata = mem_rdata;
        fin_err   = mem_err;
        if (state == S_WAIT && mem_resp_valid) begin
            finish = 1'b1;
        end else if ((state == S_ISSUE || state == S_WAIT) && timeout_hit) begin
            finish    = 1'b1;
            fin_rdata = '0;
            fin_err   = 1'b1;
        end
    end

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            state         <= S_IDLE;
            owner         <= OWN_IF;
            last_grant    <= OWN_IF;
            count         <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wmask     <= '0;
            mem_wdata     <= '0;
            if_resp_valid <= 1'b0;
            if_rdata      <= '0;
            if_err        <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_rdata      <= '0;
            ls_err        <= 1'b0;
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ls_req_ready) begin
                        state         <= S_ISSUE;
                        owner         <= OWN_LS;
                        last_grant    <= OWN_LS;
                        count         <= '0;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= ls_addr;
                        mem_we        <= ls_we;
                        mem_wmask     <= ls_wmask;
                        mem_wdata     <= ls_wdata;
                    end else if (if_req_ready) begin
                        state         <= S_ISSUE;
                        owner         <= OWN_IF;
                        last_grant    <= OWN_IF;
                        count         <= '0;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= if_addr;
                        mem_we        <= 1'b0;
                        mem_wmask     <= '0;
                        mem_wdata     <= '0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    count <= count_next[CW-1:0];
                    if (finish) begin
                        state         <= S_RESP;
                        mem_req_valid <= 1'b0;
                        if (owner == OWN_LS) begin
                            ls_resp_valid <= 1'b1;
                            ls_rdata      <= fin_rdata;
                            ls_err        <= fin_err;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_rdata      <= fin_rdata;
                            if_err        <= fin_err;
                        end
                    end else if (state == S_ISSUE && mem_req_ready) begin
                        state         <= S_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard run on a long-timeout instance plus
// directed latency, timeout and reset scenarios on a TIMEOUT=4 instance.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int force_rdly = -1;
    bit model_last_ls = 1'b0;

    mreq_t mem_exp_q[$];
    resp_t if_exp_q[$];
    resp_t ls_exp_q[$];

    // Main instance signals
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_we, ls_resp_valid, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    // Short-timeout instance signals
    logic        t_rst;
    logic        t_if_req_valid, t_if_req_ready, t_if_resp_valid, t_if_err;
    logic [31:0] t_if_addr, t_if_rdata;
    logic        t_ls_req_valid, t_ls_req_ready, t_ls_we, t_ls_resp_valid, t_ls_err;
    logic [31:0] t_ls_addr, t_ls_wdata, t_ls_rdata;
    logic [3:0]  t_ls_wmask;
    logic        t_mem_req_valid, t_mem_req_ready, t_mem_we, t_mem_resp_valid, t_mem_err;
    logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;
    logic [3:0]  t_mem_wmask;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .global_rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wmask(ls_wmask), .ls_wdata(ls_wdata),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .global_rst(t_rst),
        .if_req_valid(t_if_req_valid), .if_req_ready(t_if_req_ready), .if_addr(t_if_addr),
        .if_resp_valid(t_if_resp_valid), .if_rdata(t_if_rdata), .if_err(t_if_err),
        .ls_req_valid(t_ls_req_valid), .ls_req_ready(t_ls_req_ready), .ls_addr(t_ls_addr),
        .ls_we(t_ls_we), .ls_wmask(t_ls_wmask), .ls_wdata(t_ls_wdata),
        .ls_resp_valid(t_ls_resp_valid), .ls_rdata(t_ls_rdata), .ls_err(t_ls_err),
        .mem_req_valid(t_mem_req_valid), .mem_req_ready(t_mem_req_ready), .mem_addr(t_mem_addr),
        .mem_we(t_mem_we), .mem_wmask(t_mem_wmask), .mem_wdata(t_mem_wdata),
        .mem_resp_valid(t_mem_resp_valid), .mem_rdata(t_mem_rdata), .mem_err(t_mem_err)
    );

    // Memory contents as seen by the reference model: a fixed scramble of the address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic mem_err_of(input logic [31:0] a);
        return (a[4:2] == 3'b111);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_if(input logic [31:0] a);
        bit got = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = a;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (if_req_ready) got = 1'b1;
            @(negedge clk);
        end
        if_req_valid = 1'b0;
        if_addr      = $urandom();
        check_output("if_accepted", 32'(got), 32'd1);
    endtask

    task automatic drive_ls(input logic [31:0] a, input logic we, input logic [3:0] m, input logic [31:0] d);
        bit got = 1'b0;
        ls_req_valid = 1'b1;
        ls_addr      = a;
        ls_we        = we;
        ls_wmask     = m;
        ls_wdata     = d;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (ls_req_ready) got = 1'b1;
            @(negedge clk);
        end
        ls_req_valid = 1'b0;
        ls_addr      = $urandom();
        ls_wdata     = $urandom();
        check_output("ls_accepted", 32'(got), 32'd1);
    endtask

    // One round: issue requests together, predict grant order and responses, wait for completion.
    task automatic apply_stimulus(input bit do_if, input bit do_ls);
        mreq_t ir;
        mreq_t lr;
        bit    drained = 1'b0;
        ir.addr  = $urandom();
        ir.we    = 1'b0;
        ir.wmask = 4'h0;
        ir.wdata = 32'h0;
        lr.addr  = $urandom();
        lr.we    = 1'($urandom_range(0, 1));
        lr.wmask = 4'($urandom());
        lr.wdata = $urandom();
        if (do_if && do_ls) begin
            if (!model_last_ls) begin
                mem_exp_q.push_back(lr);
                mem_exp_q.push_back(ir);
            end else begin
                mem_exp_q.push_back(ir);
                mem_exp_q.push_back(lr);
            end
        end else if (do_ls) begin
            mem_exp_q.push_back(lr);
            model_last_ls = 1'b1;
        end else begin
            mem_exp_q.push_back(ir);
            model_last_ls = 1'b0;
        end
        if (do_if) if_exp_q.push_back({mem_data(ir.addr), mem_err_of(ir.addr)});
        if (do_ls) ls_exp_q.push_back({mem_data(lr.addr), mem_err_of(lr.addr)});
        fork
            if (do_if) drive_if(ir.addr);
            if (do_ls) drive_ls(lr.addr, lr.we, lr.wmask, lr.wdata);
        join
        for (int c = 0; c < 200 && !drained; c++) begin
            if (if_exp_q.size() == 0 && ls_exp_q.size() == 0) drained = 1'b1;
            else @(negedge clk);
        end
        check_output("round_drained", 32'(drained), 32'd1);
        if (!drained) begin
            if_exp_q.delete();
            ls_exp_q.delete();
            mem_exp_q.delete();
        end
    endtask

    // Memory responder: checks each request against the predicted order, stalls, then answers.
    initial begin
        mreq_t got;
        mreq_t exp;
        int    rd;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_err        = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req_valid) begin
                got = {mem_addr, mem_we, mem_wmask, mem_wdata};
                if (mem_exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL mem_unexpected_req: got addr 0x%08h, expected no request", mem_addr);
                end else begin
                    exp = mem_exp_q.pop_front();
                    check_output("mem_addr", got.addr, exp.addr);
                    check_output("mem_we", 32'(got.we), 32'(exp.we));
                    check_output("mem_wmask", 32'(got.wmask), 32'(exp.wmask));
                    check_output("mem_wdata", got.wdata, exp.wdata);
                end
                rd = (force_rdly >= 0) ? force_rdly : int'($urandom_range(0, 3));
                for (int i = 0; i < rd; i++) begin
                    mem_resp_valid = ($urandom_range(0, 2) == 0);
                    mem_rdata      = $urandom();
                    mem_err        = 1'($urandom());
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    check_output("stall_valid", 32'(mem_req_valid), 32'd1);
                    check_output("stall_addr", mem_addr, got.addr);
                    check_output("stall_wdata", mem_wdata, got.wdata);
                    check_output("stall_if_ready", 32'(if_req_ready), 32'd0);
                    check_output("stall_ls_ready", 32'(ls_req_ready), 32'd0);
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                check_output("mem_valid_drop", 32'(mem_req_valid), 32'd0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                mem_resp_valid = 1'b1;
                mem_rdata      = mem_data(got.addr);
                mem_err        = mem_err_of(got.addr);
                @(negedge clk);
                mem_resp_valid = 1'b0;
                mem_rdata      = $urandom();
                mem_err        = 1'b0;
            end
        end
    end

    // Response monitor: every response pulse must match the next prediction for its requester.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && if_resp_valid) begin
            if (if_exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL if_unexpected_resp: got rdata 0x%08h, expected no response", if_rdata);
            end else begin
                e = if_exp_q.pop_front();
                check_output("if_rdata", if_rdata, e.rdata);
                check_output("if_err", 32'(if_err), 32'(e.err));
            end
        end
        if (!rst && ls_resp_valid) begin
            if (ls_exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL ls_unexpected_resp: got rdata 0x%08h, expected no response", ls_rdata);
            end else begin
                e = ls_exp_q.pop_front();
                check_output("ls_rdata", ls_rdata, e.rdata);
                check_output("ls_err", 32'(ls_err), 32'(e.err));
            end
        end
    end

    // Directed latency, write, timeout and mid-transaction reset on the TIMEOUT=4 instance.
    task automatic directed_tests();
        @(negedge clk);
        t_if_req_valid = 1'b1;
        t_if_addr      = 32'h8000_0000;
        #1 check_output("to_if_ready_c0", 32'(t_if_req_ready), 32'd1);
        @(negedge clk);
        t_if_req_valid = 1'b0;
        check_output("to_mem_valid_c1", 32'(t_mem_req_valid), 32'd1);
        check_output("to_mem_addr_c1", t_mem_addr, 32'h8000_0000);
        t_mem_req_ready = 1'b1;
        @(negedge clk);
        t_mem_req_ready = 1'b0;
        check_output("to_mem_valid_c2", 32'(t_mem_req_valid), 32'd0);
        t_mem_resp_valid = 1'b1;
        t_mem_rdata      = 32'h0000_0013;
        t_mem_err        = 1'b0;
        @(negedge clk);
        t_mem_resp_valid = 1'b0;
        t_mem_rdata      = 32'hFFFF_FFFF;
        check_output("to_if_resp_c3", 32'(t_if_resp_valid), 32'd1);
        check_output("to_if_rdata_c3", t_if_rdata, 32'h13);
        check_output("to_if_err_c3", 32'(t_if_err), 32'd0);
        check_output("to_ls_resp_c3", 32'(t_ls_resp_valid), 32'd0);
        @(negedge clk);
        check_output("to_if_resp_c4", 32'(t_if_resp_valid), 32'd0);
        check_output("to_if_rdata_hold", t_if_rdata, 32'h13);
        t_ls_req_valid = 1'b1;
        t_ls_addr      = 32'h8000_1000;
        t_ls_we        = 1'b1;
        t_ls_wmask     = 4'b0011;
        t_ls_wdata     = 32'hDEAD_BEEF;
        #1 check_output("to_ls_ready_c4", 32'(t_ls_req_ready), 32'd1);
        @(negedge clk);
        t_ls_req_valid = 1'b0;
        t_ls_we        = 1'b0;
        t_ls_wmask     = 4'h0;
        t_ls_wdata     = 32'h0;
        check_output("to_wr_addr", t_mem_addr, 32'h8000_1000);
        check_output("to_wr_we", 32'(t_mem_we), 32'd1);
        check_output("to_wr_mask", 32'(t_mem_wmask), 32'h3);
        check_output("to_wr_data", t_mem_wdata, 32'hDEAD_BEEF);
        t_mem_req_ready = 1'b1;
        @(negedge clk);
        t_mem_req_ready  = 1'b0;
        t_mem_resp_valid = 1'b1;
        t_mem_rdata      = 32'hCAFE_F00D;
        @(negedge clk);
        t_mem_resp_valid = 1'b0;
        check_output("to_wr_resp", 32'(t_ls_resp_valid), 32'd1);
        check_output("to_wr_rdata", t_ls_rdata, 32'hCAFE_F00D);
        check_output("to_wr_if_quiet", 32'(t_if_resp_valid), 32'd0);
        @(negedge clk);
        check_output("to_wr_resp_once", 32'(t_ls_resp_valid), 32'd0);
        // Timeout: memory never accepts; error expected four cycles after ISSUE entry.
        t_ls_req_valid = 1'b1;
        t_ls_addr      = 32'h8000_2000;
        #1 check_output("to_tmo_ready", 32'(t_ls_req_ready), 32'd1);
        @(negedge clk);
        t_ls_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("to_tmo_issue_valid", 32'(t_mem_req_valid), 32'd1);
            check_output("to_tmo_no_resp_yet", 32'(t_ls_resp_valid), 32'd0);
            @(negedge clk);
        end
        check_output("to_tmo_resp", 32'(t_ls_resp_valid), 32'd1);
        check_output("to_tmo_err", 32'(t_ls_err), 32'd1);
        check_output("to_tmo_rdata", t_ls_rdata, 32'h0);
        check_output("to_tmo_mem_drop", 32'(t_mem_req_valid), 32'd0);
        t_mem_resp_valid = 1'b1;
        t_mem_rdata      = 32'h5555_AAAA;
        @(negedge clk);
        check_output("to_late_ls_quiet1", 32'(t_ls_resp_valid), 32'd0);
        @(negedge clk);
        t_mem_resp_valid = 1'b0;
        check_output("to_late_ls_quiet2", 32'(t_ls_resp_valid), 32'd0);
        check_output("to_late_if_quiet", 32'(t_if_resp_valid), 32'd0);
        check_output("to_late_rdata_hold", t_ls_rdata, 32'h0);
        // Reset while waiting for the memory response.
        t_ls_req_valid = 1'b1;
        t_ls_addr      = 32'h8000_4000;
        t_ls_we        = 1'b1;
        t_ls_wmask     = 4'hC;
        t_ls_wdata     = 32'h1234_5678;
        #1 check_output("to_rst_ready", 32'(t_ls_req_ready), 32'd1);
        @(negedge clk);
        t_ls_req_valid  = 1'b0;
        t_ls_we         = 1'b0;
        t_mem_req_ready = 1'b1;
        @(negedge clk);
        t_mem_req_ready = 1'b0;
        #2 t_rst = 1'b1;
        #1;
        check_output("to_rst_mem_addr", t_mem_addr, 32'h0);
        check_output("to_rst_mem_we", 32'(t_mem_we), 32'd0);
        check_output("to_rst_mem_wmask", 32'(t_mem_wmask), 32'd0);
        check_output("to_rst_mem_wdata", t_mem_wdata, 32'h0);
        check_output("to_rst_if_rdata", t_if_rdata, 32'h0);
        @(negedge clk);
        t_rst            = 1'b0;
        t_mem_resp_valid = 1'b1;
        t_mem_rdata      = 32'h0BAD_0BAD;
        @(negedge clk);
        t_mem_resp_valid = 1'b0;
        check_output("to_rst_no_ls_resp", 32'(t_ls_resp_valid), 32'd0);
        check_output("to_rst_no_if_resp", 32'(t_if_resp_valid), 32'd0);
        @(negedge clk);
        check_output("to_rst_no_ls_resp2", 32'(t_ls_resp_valid), 32'd0);
        t_if_req_valid = 1'b1;
        t_if_addr      = 32'h8000_5000;
        #1 check_output("to_post_rst_ready", 32'(t_if_req_ready), 32'd1);
        @(negedge clk);
        t_if_req_valid = 1'b0;
        check_output("to_post_rst_addr", t_mem_addr, 32'h8000_5000);
        t_mem_req_ready = 1'b1;
        @(negedge clk);
        t_mem_req_ready  = 1'b0;
        t_mem_resp_valid = 1'b1;
        t_mem_rdata      = 32'h0000_0077;
        @(negedge clk);
        t_mem_resp_valid = 1'b0;
        check_output("to_post_rst_resp", 32'(t_if_resp_valid), 32'd1);
        check_output("to_post_rst_rdata", t_if_rdata, 32'h77);
    endtask

    initial begin
        int pick;
        rst = 1'b1;
        t_rst = 1'b1;
        if_req_valid = 1'b0; if_addr = 32'h0;
        ls_req_valid = 1'b0; ls_addr = 32'h0; ls_we = 1'b0; ls_wmask = 4'h0; ls_wdata = 32'h0;
        t_if_req_valid = 1'b0; t_if_addr = 32'h0;
        t_ls_req_valid = 1'b0; t_ls_addr = 32'h0; t_ls_we = 1'b0; t_ls_wmask = 4'h0; t_ls_wdata = 32'h0;
        t_mem_req_ready = 1'b0; t_mem_resp_valid = 1'b0; t_mem_rdata = 32'h0; t_mem_err = 1'b0;
        repeat (3) @(negedge clk);
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        check_output("rst_if_ready", 32'(if_req_ready), 32'd0);
        check_output("rst_ls_ready", 32'(ls_req_ready), 32'd0);
        check_output("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'h0);
        check_output("rst_if_resp", 32'(if_resp_valid), 32'd0);
        check_output("rst_ls_resp", 32'(ls_resp_valid), 32'd0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        t_rst = 1'b0;
        @(negedge clk);
        force_rdly = 3;
        apply_stimulus(1'b1, 1'b1);
        force_rdly = -1;
        apply_stimulus(1'b1, 1'b1);
        for (int r = 0; r < 40; r++) begin
            pick = $urandom_range(1, 3);
            apply_stimulus(pick[0], pick[1]);
        end
        directed_tests();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
